alu_instr_sequencer: RTL and testbench

//  Decodes 16-bit instructions into ALU opcode/operand controls and sequences each through

---
 rtl/alu_instr_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Purpose: decodes 16-bit instructions into ALU/register-file controls and steps each through DECODE -> EXEC -> WB.
// Latency: accept at edge 0 -> DECODE cyc1, EXEC cyc2, WB cyc3 (rf_we/done), ready again cyc4; NOP/illegal retire in DECODE.
// Backpressure: instr_ready is high only in IDLE (one instruction in flight); flush aborts back to IDLE and blocks accept.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   instr/instr_valid     instruction in: [15:12] class, [11:8] Rdest, [7:4] func, [3:0] Rsrc/imm
//   instr_ready           accept qualifier, high in IDLE
//   flush                 abort the in-flight instruction
//   alu_opcode            ALU opcode (registered, valid DECODE..WB, zero in IDLE)
//   rf_raddr_a/b          register reads feeding ALU r1/r2
//   imm16, imm_sel_a/b    sign-extended immediate and which ALU operand it replaces
//   rf_we, rf_waddr       register-file write strobe (WB) and address
//   flag_we               ALU flag capture strobe (EXEC, ADD/SUB/CMP)
//   done, illegal         one-cycle retire / drop pulses
module alu_instr_sequencer #(
  parameter int NREG_BITS = 4,
  parameter int IMM_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 flush,
  output logic [7:0]           alu_opcode,
  output logic [NREG_BITS-1:0] rf_raddr_a,
  output logic [NREG_BITS-1:0] rf_raddr_b,
  output logic [15:0]          imm16,
  output logic                 imm_sel_a,
  output logic                 imm_sel_b,
  output logic                 rf_we,
  output logic [NREG_BITS-1:0] rf_waddr,
  output logic                 flag_we,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Instruction fields taken straight from the input; decode happens at accept
  // so that all ALU controls come out of flops during DECODE..WB.
  logic [3:0]           f_class;
  logic [3:0]           f_func;
  logic [NREG_BITS-1:0] f_rdest;
  logic [NREG_BITS-1:0] f_rsrc;
  logic [15:0]          f_sext;

  assign f_class = instr[15:12];
  assign f_func  = instr[7:4];
  assign f_rdest = instr[8 +: NREG_BITS];
  assign f_rsrc  = instr[NREG_BITS-1:0];
  assign f_sext  = {{(16-IMM_BITS){instr[IMM_BITS-1]}}, instr[IMM_BITS-1:0]};

  // Decoded controls
  logic [7:0]           dec_opcode;
  logic                 dec_func_ok;
  logic                 dec_legal;
  logic                 dec_nop;
  logic                 dec_ri;
  logic                 dec_src_on_a;
  logic                 dec_flag;
  logic                 dec_wr;
  logic [NREG_BITS-1:0] dec_raddr_a;
  logic [NREG_BITS-1:0] dec_raddr_b;
  logic                 dec_sel_a;
  logic                 dec_sel_b;
  logic [15:0]          dec_imm;

  always_comb begin
    dec_opcode  = 8'h00;
    dec_func_ok = 1'b1;
    unique case (f_func)
      4'h0:    dec_opcode = 8'h01;  // AND
      4'h1:    dec_opcode = 8'h02;  // OR
      4'h2:    dec_opcode = 8'h03;  // XOR
      4'h3:    dec_opcode = 8'h04;  // NOT
      4'h4:    dec_opcode = 8'h05;  // ADD
      4'h5:    dec_opcode = 8'h06;  // ADDU
      4'h6:    dec_opcode = 8'h07;  // ADDC
      4'h7:    dec_opcode = 8'h09;  // SUB
      4'h8:    dec_opcode = 8'h0B;  // CMP
      4'h9:    dec_opcode = 8'h84;  // LSH
      4'hA:    dec_opcode = 8'h08;  // RSH
      4'hB:    dec_opcode = 8'h0C;  // ALSH
      4'hC:    dec_opcode = 8'h0F;  // ARSH
      default: dec_func_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_nop      = (f_class == 4'hF);
    dec_ri       = (f_class == 4'h1);
    dec_legal    = ((f_class == 4'h0) || dec_ri) && dec_func_ok;
    // Shifts take the amount from Rsrc/imm on operand a; NOT is unary on a.
    dec_src_on_a = (f_func == 4'h3) || ((f_func >= 4'h9) && (f_func <= 4'hC));
    dec_flag     = (f_func == 4'h4) || (f_func == 4'h7) || (f_func == 4'h8);
    dec_wr       = (f_func != 4'h8);
    dec_raddr_a  = '0;
    dec_raddr_b  = '0;
    dec_sel_a    = 1'b0;
    dec_sel_b    = 1'b0;
    dec_imm      = 16'h0000;
    if (dec_legal) begin
      dec_imm = dec_ri ? f_sext : 16'h0000;
      if (dec_src_on_a) begin
        dec_sel_a   = dec_ri;
        dec_raddr_a = dec_ri ? '0 : f_rsrc;
        // Shifts operate on Rdest; NOT leaves operand b unused.
        dec_raddr_b = (f_func == 4'h3) ? '0 : f_rdest;
      end else begin
        dec_raddr_a = f_rdest;
        dec_sel_b   = dec_ri;
        dec_raddr_b = dec_ri ? '0 : f_rsrc;
      end
    end
  end

  // Sequencing
  logic accept;
  assign accept = instr_valid && (state_q == S_IDLE) && !flush;

  logic nop_q, nop_d;
  logic illegal_q, illegal_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_DECODE;
      S_DECODE: state_d = (nop_q || illegal_q) ? S_IDLE : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Registered controls: loaded on accept, held while busy, cleared whenever
  // the sequencer heads back to IDLE so outputs read zero there.
  logic [7:0]           opcode_q, opcode_d;
  logic [NREG_BITS-1:0] raddr_a_q, raddr_a_d;
  logic [NREG_BITS-1:0] raddr_b_q, raddr_b_d;
  logic [NREG_BITS-1:0] rdest_q, rdest_d;
  logic [15:0]          imm_q, imm_d;
  logic                 sel_a_q, sel_a_d;
  logic                 sel_b_q, sel_b_d;
  logic                 flag_op_q, flag_op_d;
  logic                 wr_op_q, wr_op_d;

  always_comb begin
    opcode_d  = opcode_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    rdest_d   = rdest_q;
    imm_d     = imm_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    flag_op_d = flag_op_q;
    wr_op_d   = wr_op_q;
    nop_d     = nop_q;
    illegal_d = illegal_q;
    if (state_d == S_IDLE) begin
      opcode_d  = 8'h00;
      raddr_a_d = '0;
      raddr_b_d = '0;
      rdest_d   = '0;
      imm_d     = 16'h0000;
      sel_a_d   = 1'b0;
      sel_b_d   = 1'b0;
      flag_op_d = 1'b0;
      wr_op_d   = 1'b0;
      nop_d     = 1'b0;
      illegal_d = 1'b0;
    end else if (accept) begin
      opcode_d  = dec_legal ? dec_opcode : 8'h00;
      raddr_a_d = dec_raddr_a;
      raddr_b_d = dec_raddr_b;
      rdest_d   = f_rdest;
      imm_d     = dec_imm;
      sel_a_d   = dec_sel_a;
      sel_b_d   = dec_sel_b;
      flag_op_d = dec_legal && dec_flag;
      wr_op_d   = dec_legal && dec_wr;
      nop_d     = dec_nop;
      illegal_d = !dec_nop && !dec_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= 8'h00;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      rdest_q   <= '0;
      imm_q     <= 16'h0000;
      sel_a_q   <= 1'b0;
      sel_b_q   <= 1'b0;
      flag_op_q <= 1'b0;
      wr_op_q   <= 1'b0;
      nop_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      rdest_q   <= rdest_d;
      imm_q     <= imm_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      flag_op_q <= flag_op_d;
      wr_op_q   <= wr_op_d;
      nop_q     <= nop_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are gated combinationally by flush so an aborted instruction
  // never commits in the cycle it is flushed.
  assign instr_ready = (state_q == S_IDLE);
  assign alu_opcode  = opcode_q;
  assign rf_raddr_a  = raddr_a_q;
  assign rf_raddr_b  = raddr_b_q;
  assign imm16       = imm_q;
  assign imm_sel_a   = sel_a_q;
  assign imm_sel_b   = sel_b_q;
  assign flag_we     = (state_q == S_EXEC) && flag_op_q && !flush;
  assign rf_we       = (state_q == S_WB) && wr_op_q && !flush;
  assign rf_waddr    = (state_q == S_WB) ? rdest_q : '0;
  assign done        = ((state_q == S_WB) || ((state_q == S_DECODE) && nop_q)) && !flush;
  assign illegal     = (state_q == S_DECODE) && illegal_q && !flush;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: an instruction-level model (busy flag plus
// age since accept) predicts every output on each falling edge, and directed
// vectors pin hand-computed values at known cycles.
module tb_alu_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [7:0]  alu_opcode;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [15:0] imm16;
  logic        imm_sel_a;
  logic        imm_sel_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        flag_we;
  logic        done;
  logic        illegal;

  alu_instr_sequencer #(.NREG_BITS(4), .IMM_BITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .alu_opcode  (alu_opcode),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .imm16       (imm16),
    .imm_sel_a   (imm_sel_a),
    .imm_sel_b   (imm_sel_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .flag_we     (flag_we),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  localparam logic [7:0] OPC [0:12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                        8'h09, 8'h0B, 8'h84, 8'h08, 8'h0C, 8'h0F};
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  logic [15:0] m_instr = 16'h0000;

  function automatic bit is_legal(input logic [15:0] i);
    return (i[15:12] <= 4'h1) && (i[7:4] <= 4'hC);
  endfunction

  // An instruction lives for 3 cycles (legal), 1 cycle (NOP/illegal), or until flush/reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (flush) m_busy = 1'b0;
      else if (m_age == 3 || (m_age == 1 && !is_legal(m_instr))) m_busy = 1'b0;
      else m_age++;
    end else if (instr_valid && !flush) begin
      m_busy  = 1'b1;
      m_age   = 1;
      m_instr = instr;
    end
  end

  always @(negedge clk) begin
    logic [3:0] cls, rd, fn, rs;
    bit nop, legal, ri, src_a;
    if (!rst_n || !m_busy) begin
      chk("idle_ready",   instr_ready, 1);
      chk("idle_opcode",  alu_opcode, 0);
      chk("idle_raddr_a", rf_raddr_a, 0);
      chk("idle_raddr_b", rf_raddr_b, 0);
      chk("idle_imm16",   imm16, 0);
      chk("idle_sel",     {imm_sel_a, imm_sel_b}, 0);
      chk("idle_strobes", {rf_we, flag_we, done, illegal}, 0);
    end else begin
      cls = m_instr[15:12]; rd = m_instr[11:8]; fn = m_instr[7:4]; rs = m_instr[3:0];
      nop   = (cls == 4'hF);
      legal = is_legal(m_instr);
      ri    = (cls == 4'h1);
      chk("busy_ready", instr_ready, 0);
      chk("illegal", illegal, (m_age == 1) && !nop && !legal && !flush);
      chk("done",    done, !flush && (m_age == 3 || (m_age == 1 && nop)));
      chk("flag_we", flag_we, !flush && m_age == 2 && (fn == 4'h4 || fn == 4'h7 || fn == 4'h8));
      chk("rf_we",   rf_we, !flush && m_age == 3 && fn != 4'h8);
      if (rf_we === 1'b1) chk("rf_waddr", rf_waddr, rd);
      if (legal) begin
        chk("opcode", alu_opcode, OPC[fn]);
        if (ri) chk("imm16", imm16, {{12{rs[3]}}, rs});
        src_a = (fn == 4'h3) || (fn >= 4'h9 && fn <= 4'hC);
        if (src_a) begin
          chk("sel_a", imm_sel_a, ri);
          chk("sel_b", imm_sel_b, 0);
          if (!ri) chk("raddr_a_src", rf_raddr_a, rs);
          if (fn != 4'h3) chk("raddr_b_dst", rf_raddr_b, rd);
        end else begin
          chk("sel_a", imm_sel_a, 0);
          chk("sel_b", imm_sel_b, ri);
          chk("raddr_a_dst", rf_raddr_a, rd);
          if (!ri) chk("raddr_b_src", rf_raddr_b, rs);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int k = 0;
    while (instr_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) chk("idle_timeout", 0, 1);
  endtask

  // Returns #1 after the accepting edge, i.e. at the start of cycle 1 (DECODE).
  task automatic send(input logic [15:0] i);
    @(posedge clk); #1;
    wait_idle();
    instr       = i;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  localparam int NSWEEP = 18;
  localparam logic [15:0] SWEEP [0:NSWEEP-1] = '{
    16'h0005, 16'h0112, 16'h0227, 16'h1366, 16'h1456, 16'h0567, 16'h06A8, 16'h07B9,
    16'h0CC1, 16'h1DBF, 16'h1A98, 16'h0EE0, 16'h1F00, 16'h3123, 16'hF4A5, 16'h1038,
    16'h1C3E, 16'h0B72};

  initial begin
    int acc;
    rst_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_outs", {alu_opcode, rf_we, flag_we, done, illegal}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD R3,R5 is 16'h0345 in the class/Rdest/func/Rsrc layout.
    send(16'h0345);
    @(negedge clk);
    chk("add_c1_opcode", alu_opcode, 8'h05);
    chk("add_c1_ra", rf_raddr_a, 4'd3);
    chk("add_c1_rb", rf_raddr_b, 4'd5);
    @(negedge clk);
    chk("add_c2_flag_we", flag_we, 1);
    @(negedge clk);
    chk("add_c3_rf_we", rf_we, 1);
    chk("add_c3_waddr", rf_waddr, 4'd3);
    chk("add_c3_done", done, 1);
    @(negedge clk);
    chk("add_c4_ready", instr_ready, 1);

    // 16'h0435 decodes as NOT R4 <- R5.
    send(16'h0435);
    @(negedge clk);
    chk("not_opcode", alu_opcode, 8'h04);
    chk("not_ra", rf_raddr_a, 4'd5);

    send(16'h127F);
    @(negedge clk);
    chk("subi_imm16", imm16, 16'hFFFF);
    chk("subi_sel_b", imm_sel_b, 1);
    chk("subi_opcode", alu_opcode, 8'h09);
    @(negedge clk); @(negedge clk);
    chk("subi_rf_we", rf_we, 1);

    send(16'h1193);
    @(negedge clk);
    chk("lsh_opcode", alu_opcode, 8'h84);
    chk("lsh_sel_a", imm_sel_a, 1);
    chk("lsh_imm16", imm16, 16'h0003);
    chk("lsh_rb", rf_raddr_b, 4'd1);

    send(16'h0481);
    @(negedge clk); @(negedge clk);
    chk("cmp_flag_we", flag_we, 1);
    @(negedge clk);
    chk("cmp_no_rf_we", rf_we, 0);
    chk("cmp_done", done, 1);

    send(16'h00D0);
    @(negedge clk);
    chk("funcD_illegal", illegal, 1);
    chk("funcD_quiet", {rf_we, flag_we, done}, 0);
    @(negedge clk);
    chk("funcD_idle", instr_ready, 1);

    send(16'h2000);
    @(negedge clk);
    chk("cls2_illegal", illegal, 1);
    chk("cls2_quiet", {rf_we, flag_we, done}, 0);
    @(negedge clk);
    chk("cls2_idle", instr_ready, 1);

    send(16'hF000);
    @(negedge clk);
    chk("nop_done", done, 1);
    chk("nop_no_we", rf_we, 0);
    @(negedge clk);
    chk("nop_idle", instr_ready, 1);

    // Back-to-back: valid held high for 13 edges -> accepts at edges 1, 5, 9, 13.
    @(posedge clk); #1;
    wait_idle();
    instr = 16'h0481; instr_valid = 1'b1; acc = 0;
    repeat (13) begin
      @(negedge clk);
      if (instr_ready) acc++;
    end
    @(posedge clk); #1 instr_valid = 1'b0;
    chk("b2b_accepts", acc, 4);

    // Flush during EXEC.
    send(16'h0345);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_flag_we", flag_we, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", instr_ready, 1);
    chk("flush_no_rf_we", rf_we, 0);

    // Flush with valid in IDLE must not accept.
    @(posedge clk); #1 flush = 1'b1; instr_valid = 1'b1; instr = 16'h0345;
    @(posedge clk); #1 flush = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_noacc", instr_ready, 1);
    chk("flush_idle_opcode", alu_opcode, 0);

    // Reset asserted while in WB.
    send(16'h0345);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstwb_no_rf_we", rf_we, 0);
    chk("rstwb_no_done", done, 0);
    chk("rstwb_ready", instr_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstwb_ready_after", instr_ready, 1);

    // Sweep of other encodings, checked by the model alone.
    for (int s = 0; s < NSWEEP; s++) send(SWEEP[s]);
    @(posedge clk); #1;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
